hwt_tester: RTL and testbench
=============================

HWT_TESTER -- requirements
Module: hwt_tester

Interface
REQ-001 SHALL provide parameter PASSES, default 4, meaning the number of full 16-vector sweeps per test run, legal range 1..255.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 SHALL provide port start, input, 1 bit: run request, level-sampled in IDLE.
REQ-005 SHALL provide port dut_y, input, 1 bit: Y output of the 4-input circuit under test, combinational from a..d.
REQ-006 SHALL provide ports a, b, c, d, outputs, 1 bit each, registered: stimulus to DUT inputs A..D.
REQ-007 SHALL provide port busy, output, 1 bit: high while in RUN.
REQ-008 SHALL provide port done, output, 1 bit: one-cycle pulse at end of run.
REQ-009 SHALL provide port fail, output, 1 bit: sticky, set when any mismatch occurs during a run.
REQ-010 SHALL provide port err_count, output, 8 bits: mismatch count, saturating at 255.
REQ-011 SHALL provide port first_err_vec, output, 4 bits: vector {a,b,c,d} of the first mismatch in the run.
REQ-012 SHALL provide port first_err_pass, output, 8 bits: pass index (0-based) of the first mismatch in the run.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: a..d=0, busy=0; start=1 -> RUN next edge, with vec=0, pass=0, err_count=0, fail=0, first_err_vec=0, first_err_pass=0.
REQ-015 SHALL map the internal 4-bit vec as vec[3]=a, vec[2]=b, vec[1]=c, vec[0]=d, with a..d driven from vec only in RUN.
REQ-016 SHALL compute golden output g = d & ((a & b) | c) from the currently driven vector.
REQ-017 Each RUN edge SHALL compare dut_y with g for the currently driven vector; mismatch -> err_count+1 (hold at 255), fail=1.
REQ-018 On the first mismatch of a run, SHALL capture first_err_vec=vec and first_err_pass=pass; later mismatches SHALL leave both unchanged.
REQ-019 After each compare, SHALL increment vec modulo 16; vec wrap 15->0 SHALL increment pass.
REQ-020 After the compare of vec=15 in pass PASSES-1, SHALL go to DONE; RUN SHALL last exactly 16*PASSES cycles.
REQ-021 DONE: done=1, busy=0, a..d=0 for exactly one cycle, then IDLE unconditionally.
REQ-022 start SHALL be ignored in RUN and DONE; start held high SHALL begin a new run on the first IDLE cycle after DONE.
REQ-023 fail, err_count, first_err_vec and first_err_pass SHALL hold their values from DONE until the next run starts.
REQ-024 Saturation: with err_count=255 and a further mismatch, err_count SHALL stay 255 and fail SHALL stay 1.

Reset
REQ-025 While rst=1, SHALL force immediately, independent of clk: state=IDLE, vec=0, pass=0, a=b=c=d=0, busy=0, done=0, fail=0, err_count=0, first_err_vec=0, first_err_pass=0.
REQ-026 Reset mid-run SHALL abort the run with no done pulse; the next run SHALL start from vec=0, pass=0.

Verification
REQ-027 Golden DUT (dut_y=g), PASSES=4, one-cycle start -> busy high 64 cycles, done pulse on cycle 65, fail=0, err_count=0.
REQ-028 dut_y stuck 0, PASSES=4 -> mismatches at vectors 3,7,11,13,15 each pass, err_count=20, fail=1, first_err_vec=4'h3, first_err_pass=0.
REQ-029 Trojan model (dut_y=~g only when pass=2 and vec=4'hF) -> err_count=1, first_err_vec=4'hF, first_err_pass=2, fail=1.
REQ-030 dut_y=~g, PASSES=20 -> 320 mismatches, err_count=255 (saturated), first_err_vec=0, first_err_pass=0.
REQ-031 rst pulsed at pass 1, vec 5 -> all outputs 0 asynchronously, no done; new start -> a..d=0000 on first RUN cycle, full 64-cycle run.
REQ-032 start held high, golden DUT -> runs back to back with IDLE for one cycle between done and next busy; start toggled during RUN has no effect.

Source files
------------

// File: rtl/hwt_tester.sv
// hwt_tester: hardware self-tester for a 4-input combinational circuit.
// Runs PASSES exhaustive sweeps of the 16 input vectors, compares the circuit
// output against the golden function g = d & ((a & b) | c), and records the
// mismatch count together with the position of the first mismatch.
module hwt_tester #(
    parameter int unsigned PASSES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [7:0] err_count,
    output logic [3:0] first_err_vec,
    output logic [7:0] first_err_pass
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam logic [7:0] LastPass = 8'(PASSES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] vec;
    logic [7:0] pass;
    logic       golden;
    logic       mismatch;
    logic       last_vec;

    // Golden model and compare against the vector currently on a..d
    always_comb begin
        golden   = vec[0] & ((vec[3] & vec[2]) | vec[1]);
        mismatch = (state == StRun) && (dut_y != golden);
        last_vec = (vec == 4'hF) && (pass == LastPass);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start only matters in IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            StIdle:  if (start) state_next = StRun;
            StRun:   if (last_vec) state_next = StDone;
            StDone:  state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    // Output decode; vec is zero outside RUN, so a..d come straight from its flops
    always_comb begin
        busy = (state == StRun);
        done = (state == StDone);
        a    = vec[3];
        b    = vec[2];
        c    = vec[1];
        d    = vec[0];
    end

    // Sweep counters and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec            <= 4'h0;
            pass           <= 8'h00;
            err_count      <= 8'h00;
            fail           <= 1'b0;
            first_err_vec  <= 4'h0;
            first_err_pass <= 8'h00;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        vec            <= 4'h0;
                        pass           <= 8'h00;
                        err_count      <= 8'h00;
                        fail           <= 1'b0;
                        first_err_vec  <= 4'h0;
                        first_err_pass <= 8'h00;
                    end
                end
                StRun: begin
                    // The final increment wraps vec to 0, which blanks a..d in DONE
                    vec <= vec + 4'd1;
                    if (vec == 4'hF) begin
                        pass <= pass + 8'd1;
                    end
                    if (mismatch) begin
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        fail <= 1'b1;
                        // fail is still clear only before the first mismatch of the run
                        if (!fail) begin
                            first_err_vec  <= vec;
                            first_err_pass <= pass;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hwt_tester.sv
// Directed bench for hwt_tester: golden, stuck-at-0, trojan, saturation,
// mid-run reset and back-to-back runs.
module tb_hwt_tester;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start2;
    logic       dut_y;
    logic       dut_y2;
    logic       a, b, c, d, busy, done, fail;
    logic [7:0] err_count;
    logic [3:0] first_err_vec;
    logic [7:0] first_err_pass;
    logic       a2, b2, c2, d2, busy2, done2, fail2;
    logic [7:0] err_count2;
    logic [3:0] first_err_vec2;
    logic [7:0] first_err_pass2;

    int checks   = 0;
    int failures = 0;

    // 0 = golden, 1 = stuck at 0, 2 = trojan in third sweep at vector F
    int mode = 0;
    int fcnt = 0;
    int fbase = 0;

    logic g, g2, troj;

    always #5 clk = ~clk;

    hwt_tester #(.PASSES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dut_y(dut_y),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .fail(fail),
        .err_count(err_count), .first_err_vec(first_err_vec),
        .first_err_pass(first_err_pass)
    );

    hwt_tester #(.PASSES(20)) dut20 (
        .clk(clk), .rst(rst), .start(start2), .dut_y(dut_y2),
        .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .fail(fail2),
        .err_count(err_count2), .first_err_vec(first_err_vec2),
        .first_err_pass(first_err_pass2)
    );

    // Circuit-under-test models
    assign g      = d & ((a & b) | c);
    assign g2     = d2 & ((a2 & b2) | c2);
    assign troj   = busy && ({a, b, c, d} == 4'hF) && (fcnt - fbase == 2);
    assign dut_y  = (mode == 1) ? 1'b0 : ((mode == 2) && troj) ? ~g : g;
    assign dut_y2 = ~g2;

    // Number of completed vector-F compares, used to locate the third sweep
    always @(posedge clk) begin
        if (busy && ({a, b, c, d} == 4'hF)) fcnt <= fcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts busy negedges until done is seen (or the budget runs out)
    task automatic measure(input bit toggle, output int nbusy, output bit saw_done);
        nbusy    = 0;
        saw_done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            if (busy) nbusy++;
            if (toggle) start = ~start;
            @(negedge clk);
        end
    endtask

    // Raises start for one edge; leaves us on the first RUN negedge
    task automatic kick(input bit hold);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        int nb;
        bit sd;

        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        #1;
        chk("reset_outputs", {a, b, c, d, busy, done, fail}, 7'b0);
        chk("reset_counts", {err_count, first_err_vec, first_err_pass}, 20'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // Golden circuit
        mode = 0;
        kick(1'b0);
        measure(1'b0, nb, sd);
        chk("gold_done_seen", sd, 1'b1);
        chk("gold_busy_cycles", nb, 64);
        chk("gold_done_abcd", {a, b, c, d, busy}, 5'b0);
        chk("gold_fail", fail, 1'b0);
        chk("gold_err", err_count, 8'd0);
        @(negedge clk);
        chk("gold_done_one_cycle", {done, busy}, 2'b00);

        // Stuck-at-0: misses at 3,7,11,13,15 every sweep
        mode = 1;
        kick(1'b0);
        measure(1'b0, nb, sd);
        chk("sa0_done_seen", sd, 1'b1);
        chk("sa0_err", err_count, 8'd20);
        chk("sa0_fail", fail, 1'b1);
        chk("sa0_first_vec", first_err_vec, 4'h3);
        chk("sa0_first_pass", first_err_pass, 8'd0);
        repeat (3) @(negedge clk);
        chk("sa0_hold_after_done", {fail, err_count, first_err_vec, first_err_pass},
            {1'b1, 8'd20, 4'h3, 8'd0});

        // Trojan: a single flip in sweep 2 at vector F
        mode  = 2;
        fbase = fcnt;
        kick(1'b0);
        measure(1'b0, nb, sd);
        chk("troj_done_seen", sd, 1'b1);
        chk("troj_err", err_count, 8'd1);
        chk("troj_fail", fail, 1'b1);
        chk("troj_first_vec", first_err_vec, 4'hF);
        chk("troj_first_pass", first_err_pass, 8'd2);
        mode = 0;

        // Inverted circuit, 20 sweeps: 320 misses saturate at 255
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        sd = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (done2) begin
                sd = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("sat_done_seen", sd, 1'b1);
        chk("sat_err", err_count2, 8'd255);
        chk("sat_fail", fail2, 1'b1);
        chk("sat_first", {first_err_vec2, first_err_pass2}, 12'h000);

        // Mid-run reset at sweep 1, vector 5
        mode = 1;
        kick(1'b0);
        repeat (21) @(negedge clk);
        chk("rst_pre_vec", {busy, a, b, c, d}, 5'b1_0101);
        chk("rst_pre_fail", fail, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outputs", {a, b, c, d, busy, done, fail}, 7'b0);
        chk("rst_async_counts", {err_count, first_err_vec, first_err_pass}, 20'h0);
        @(negedge clk);
        rst = 1'b0;
        sd = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) sd = 1'b1;
        end
        chk("rst_no_done", sd, 1'b0);
        mode = 0;
        kick(1'b0);
        chk("rst_restart_abcd", {busy, a, b, c, d}, 5'b1_0000);
        measure(1'b0, nb, sd);
        chk("rst_restart_done", sd, 1'b1);
        chk("rst_restart_cycles", nb, 64);

        // start held high: one IDLE cycle between runs; toggling in RUN is ignored
        kick(1'b1);
        measure(1'b0, nb, sd);
        chk("b2b_first_done", sd, 1'b1);
        chk("b2b_first_cycles", nb, 64);
        @(negedge clk);
        chk("b2b_idle_gap", {busy, done}, 2'b00);
        @(negedge clk);
        chk("b2b_second_busy", busy, 1'b1);
        measure(1'b1, nb, sd);
        start = 1'b0;
        chk("b2b_second_done", sd, 1'b1);
        chk("b2b_toggle_cycles", nb, 64);
        chk("b2b_fail", fail, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
